// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad ID entry block: key codes, scan FSM
// states, the 4x4 key map and small row-pattern helpers.
package keypad_pkg;

  // Key codes presented on oKEY_CODE; digits 0-9 use their own value.
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Cycles after a column change before the two-flop synchroniser shows
  // rows belonging to the newly driven column.
  localparam int SCAN_SETTLE = 2;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2,
    ST_RELEASE  = 2'd3
  } scan_state_e;

  // KEY_MAP[row][col]; ascending ranges so the table reads like the keypad.
  localparam logic [0:3][0:3][3:0] KEY_MAP = {
    4'd1,     4'd2, 4'd3,     KEY_A,
    4'd4,     4'd5, 4'd6,     KEY_B,
    4'd7,     4'd8, 4'd9,     KEY_C,
    KEY_STAR, 4'd0, KEY_HASH, KEY_D
  };

  // True when exactly one active-low row is asserted.
  function automatic logic single_low(input logic [3:0] rows);
    return (rows == 4'b1110) || (rows == 4'b1101) ||
           (rows == 4'b1011) || (rows == 4'b0111);
  endfunction

  // Index of the lowest asserted (low) row.
  function automatic logic [1:0] row_of(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    if (!rows[3]) idx = 2'd3;
    if (!rows[2]) idx = 2'd2;
    if (!rows[1]) idx = 2'd1;
    if (!rows[0]) idx = 2'd0;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Connection between the keypad scanner and its consumer.
// key_strobe is a one-cycle pulse qualifying key_code; there is no ready,
// the consumer must accept every strobe in the cycle it is high.
// state exposes the scan FSM for debug and checker binding.
interface keypad_if;
  import keypad_pkg::*;

  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic [3:0]  key_code;
  logic        key_strobe;
  scan_state_e state;

  modport master (input key_row, output key_col, output key_code,
                  output key_strobe, output state);
  modport slave  (output key_row, input key_col, input key_code,
                  input key_strobe, input state);
endinterface

// File: rtl/keypad_scan.sv
// Keypad scanner: row synchroniser, column rotation, scan FSM and debounce.
// Emits one strobe per debounced key press, none while the key is held.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS = 50000,
  parameter int DEB_TICKS  = 1000000
) (
  input  logic     iCLK,
  input  logic     iRST_N,
  keypad_if.master kif
);

  localparam int SW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int DW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;

  logic [3:0]    row_s1_q, row_s2_q;
  logic [3:0]    pat_q, pat_d;
  logic [3:0]    code_q, code_d;
  logic [1:0]    col_q, col_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          strobe_q, strobe_d;
  scan_state_e   state_q, state_d;

  assign kif.key_col    = ~(4'b0001 << col_q);
  assign kif.key_code   = code_q;
  assign kif.key_strobe = strobe_q;
  assign kif.state      = state_q;

  // Two-flop synchroniser for the asynchronous, pulled-up row inputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= kif.key_row;
      row_s2_q <= row_s1_q;
    end
  end

  // Scan FSM state and counter registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= ST_SCAN;
      col_q      <= 2'd0;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      pat_q      <= 4'hF;
      code_q     <= 4'd0;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      pat_q      <= pat_d;
      code_q     <= code_d;
      strobe_q   <= strobe_d;
    end
  end

  // Next-state logic: rotate, detect a single-row press, debounce, hold, release.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    pat_d      = pat_q;
    code_d     = code_q;
    strobe_d   = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (scan_cnt_q == SW'(SCAN_TICKS - 1)) begin
          scan_cnt_d = '0;
          col_d      = col_q + 2'd1;
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
        // Rows are only trusted once the synchroniser reflects this column.
        if (scan_cnt_q >= SW'(SCAN_SETTLE) && single_low(row_s2_q)) begin
          state_d    = ST_DEBOUNCE;
          pat_d      = row_s2_q;
          col_d      = col_q;
          scan_cnt_d = '0;
          deb_cnt_d  = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (row_s2_q != pat_q) begin
          state_d    = ST_SCAN;
          scan_cnt_d = '0;
        end else if (deb_cnt_q == DW'(DEB_TICKS - 1)) begin
          state_d  = ST_HOLD;
          strobe_d = 1'b1;
          code_d   = KEY_MAP[row_of(pat_q)][col_q];
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (row_s2_q == 4'hF) begin
          state_d   = ST_RELEASE;
          deb_cnt_d = '0;
        end
      end
      ST_RELEASE: begin
        if (row_s2_q != 4'hF) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DW'(DEB_TICKS - 1)) begin
          state_d    = ST_SCAN;
          scan_cnt_d = '0;
          deb_cnt_d  = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

endmodule

// File: rtl/keypad_id_entry.sv
// Keypad ID entry top: scans a 4x4 keypad and assembles a seven-digit BCD ID.
// Optional feature macro KEYPAD_BACKSPACE_EN makes D delete the last digit;
// without it D is an inert key like A-C.
module keypad_id_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS = 50000,
  parameter int DEB_TICKS  = 1000000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [3:0]  KEY_ROW,
  output logic [3:0]  KEY_COL,
  output logic [3:0]  oKEY_CODE,
  output logic        oKEY_STROBE,
  output logic [27:0] oID,
  output logic [2:0]  oDIGIT_CNT,
  output logic        oID_VALID,
  output logic        oID_ERR
);

  keypad_if kif ();

  assign kif.key_row  = KEY_ROW;
  assign KEY_COL      = kif.key_col;
  assign oKEY_CODE    = kif.key_code;
  assign oKEY_STROBE  = kif.key_strobe;

  keypad_scan #(
    .SCAN_TICKS (SCAN_TICKS),
    .DEB_TICKS  (DEB_TICKS)
  ) u_scan (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .kif    (kif)
  );

  logic [27:0] id_q, id_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  assign oID        = id_q;
  assign oDIGIT_CNT = cnt_q;
  assign oID_VALID  = valid_q;
  assign oID_ERR    = err_q;

  // ID assembly registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      id_q    <= 28'h0;
      cnt_q   <= 3'd0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Act on each accepted key; done_q marks a completed ID still on display.
  always_comb begin
    id_d    = id_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (kif.key_strobe) begin
      if (kif.key_code < 4'd10) begin
        if (cnt_q < 3'd7) begin
          id_d   = {(done_q ? 24'h0 : id_q[23:0]), kif.key_code};
          cnt_d  = cnt_q + 3'd1;
          done_d = 1'b0;
        end
      end else begin
        case (kif.key_code)
          KEY_STAR: begin
            id_d   = 28'h0;
            cnt_d  = 3'd0;
            done_d = 1'b0;
          end
          KEY_HASH: begin
            if (cnt_q == 3'd7) begin
              valid_d = 1'b1;
              cnt_d   = 3'd0;
              done_d  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
`ifdef KEYPAD_BACKSPACE_EN
          KEY_D: begin
            if (cnt_q != 3'd0) begin
              id_d  = {4'h0, id_q[27:4]};
              cnt_d = cnt_q - 3'd1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule
